// File: rtl/histo_pkg.sv
// Shared constants and state encoding for the histogram RAM sequencer.
package histo_pkg;
  localparam int HISTO_ADDR_W = 12;
  localparam int HISTO_NCH    = 8;
  localparam int HISTO_SEL_W  = $clog2(HISTO_NCH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ACQ   = 3'd2,
    DRAIN = 3'd3,
    READY = 3'd4
  } histo_state_t;
endpackage

// File: rtl/histo_prio_enc.sv
// Lowest-set-bit priority encoder over the channel mask.
module histo_prio_enc
  import histo_pkg::*;
(
  input  logic [HISTO_NCH-1:0]   reqMask,
  output logic [HISTO_SEL_W-1:0] idx,
  output logic                   valid
);
  // Scanning downward lets the lowest set bit be the last (winning) assignment.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = HISTO_NCH - 1; i >= 0; i--) begin
      if (reqMask[i]) begin
        idx   = HISTO_SEL_W'(i);
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/histo_sequencer.sv
// Channel scheduler for the ADC histogram RAM: clear, acquire, drain, hand off.
// Optional readout timeout is built only when HISTO_SEQ_TIMEOUT_EN is defined.
module histo_sequencer
  import histo_pkg::*;
#(
  parameter int ADDR_W      = HISTO_ADDR_W,
  parameter int CNT_W       = 32,
  parameter int DRAIN_CYC   = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [HISTO_NCH-1:0]   CH_MASK,
  input  logic [CNT_W-1:0]       SAMPLE_COUNT,
  input  logic                   SAMPLE_VALID,
  input  logic                   READOUT_DONE,
  output logic [HISTO_SEL_W-1:0] ADC_SEL,
  output logic                   HISTO_EN,
  output logic                   CLR_WE,
  output logic [ADDR_W-1:0]      CLR_ADDR,
  output logic                   BUSY,
  output logic                   CH_READY,
  output logic                   DONE,
  output logic [CNT_W-1:0]       SAMPLES_TAKEN,
  output logic                   TIMEOUT_ERR,
  output logic [2:0]             STATE_DBG
);
  // Handshakes: SAMPLE_VALID is a single-cycle strobe counted only while HISTO_EN
  // is high; CH_READY is a level held until a single-cycle READOUT_DONE is seen
  // in the same cycle, which consumes the channel. Strobes in other states are dropped.
  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

  histo_state_t state, nextState;

  logic [HISTO_NCH-1:0]   chMask;
  logic [CNT_W-1:0]       target;
  logic [CNT_W-1:0]       samplesTaken;
  logic [CNT_W-1:0]       samplesInc;
  logic [ADDR_W-1:0]      clrAddr;
  logic [DRAIN_W-1:0]     drainCnt;
  logic [HISTO_SEL_W-1:0] adcSel;
  logic                   doneReg;
  logic                   advance;
  logic                   sampleHit;
  logic [HISTO_NCH-1:0]   selBit;
  logic [HISTO_NCH-1:0]   remMask;
  logic [HISTO_NCH-1:0]   encIn;
  logic [HISTO_SEL_W-1:0] encIdx;
  logic                   encValid;

  assign selBit     = HISTO_NCH'(1) << adcSel;
  assign remMask    = chMask & ~selBit;
  assign samplesInc = samplesTaken + CNT_W'(1);
  assign sampleHit  = (samplesInc == target);
  // One encoder serves both the START pick and the post-readout advance.
  assign encIn      = (state == IDLE) ? CH_MASK : remMask;

  histo_prio_enc uPrioEnc (
    .reqMask (encIn),
    .idx     (encIdx),
    .valid   (encValid)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (START && CH_MASK != '0) nextState = CLEAR;
      CLEAR:   if (clrAddr == {ADDR_W{1'b1}}) nextState = ACQ;
      ACQ:     if (SAMPLE_VALID && sampleHit) nextState = DRAIN;
      DRAIN:   if (drainCnt == DRAIN_W'(DRAIN_CYC - 1)) nextState = READY;
      READY:   if (advance) nextState = encValid ? CLEAR : IDLE;
      default: nextState = IDLE;
    endcase
    if (ABORT) nextState = IDLE;
  end

  always_comb begin
    BUSY     = (state != IDLE);
    HISTO_EN = (state == ACQ);
    CLR_WE   = (state == CLEAR);
    CH_READY = (state == READY);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      chMask       <= '0;
      target       <= '0;
      samplesTaken <= '0;
      clrAddr      <= '0;
      drainCnt     <= '0;
      adcSel       <= '0;
      doneReg      <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (!ABORT) begin
        case (state)
          IDLE: begin
            if (START) begin
              if (CH_MASK == '0) begin
                doneReg <= 1'b1;
              end else begin
                chMask       <= CH_MASK;
                target       <= (SAMPLE_COUNT == '0) ? CNT_W'(1) : SAMPLE_COUNT;
                adcSel       <= encIdx;
                clrAddr      <= '0;
                samplesTaken <= '0;
              end
            end
          end
          CLEAR: clrAddr <= clrAddr + ADDR_W'(1);
          ACQ: begin
            drainCnt <= '0;
            if (SAMPLE_VALID) samplesTaken <= samplesInc;
          end
          DRAIN: drainCnt <= drainCnt + DRAIN_W'(1);
          READY: begin
            if (advance) begin
              chMask <= remMask;
              if (encValid) begin
                adcSel       <= encIdx;
                clrAddr      <= '0;
                samplesTaken <= '0;
              end else begin
                doneReg <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef HISTO_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] toCnt;
  logic            toHit;
  logic            timeoutErr;

  assign toHit   = (toCnt == TO_W'(TIMEOUT_CYC - 1));
  assign advance = READOUT_DONE | toHit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      toCnt      <= '0;
      timeoutErr <= 1'b0;
    end else begin
      toCnt <= (state == READY && nextState == READY) ? toCnt + TO_W'(1) : '0;
      if (!ABORT && state == IDLE && START)
        timeoutErr <= 1'b0;
      else if (!ABORT && state == READY && toHit && !READOUT_DONE)
        timeoutErr <= 1'b1;
    end
  end

  assign TIMEOUT_ERR = timeoutErr;
`else
  assign advance     = READOUT_DONE;
  // Constant zero; the term only keeps the parameter referenced in this build.
  assign TIMEOUT_ERR = 1'b0 & (TIMEOUT_CYC == 0);
`endif

  assign ADC_SEL       = adcSel;
  assign CLR_ADDR      = clrAddr;
  assign SAMPLES_TAKEN = samplesTaken;
  assign DONE          = doneReg;
  assign STATE_DBG     = state;
endmodule

// File: doc/histo_sequencer.md
Name: histo_sequencer

Overview:
- Scheduler for the ADC histogram RAM (4096x32, one channel histogrammed at a time).
- Walks the enabled channels in CH_MASK, lowest index first. For each channel it clears the RAM, runs the histogram for SAMPLE_COUNT valid ADC samples, then hands the RAM to the user side for readout.
- Sits between the control-register block and the histogrammer datapath, driving its channel select, enable and clear-write controls.

Parameters:
- ADDR_W, 12, histogram RAM address width (bins = 2**ADDR_W).
- CNT_W, 32, sample counter width.
- DRAIN_CYC, 4, cycles HISTO_EN stays low before READY, letting the read-modify-write pipeline retire.
- TIMEOUT_CYC, 1000000, readout timeout in cycles; used only with HISTO_SEQ_TIMEOUT_EN.

Ports:
- CLK  in  1  single system clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- START  in  1  one-cycle pulse; begins a scan; ignored unless IDLE.
- ABORT  in  1  one-cycle pulse; returns to IDLE from any state.
- CH_MASK  in  8  channel enable mask; sampled at START.
- SAMPLE_COUNT  in  CNT_W  samples per channel; sampled at START; 0 treated as 1.
- SAMPLE_VALID  in  1  one-cycle strobe per new ADC sample (datapath data-valid).
- READOUT_DONE  in  1  one-cycle pulse from user side: histogram read out.
- ADC_SEL  out  3  channel under test.
- HISTO_EN  out  1  histogram accumulation enable.
- CLR_WE  out  1  RAM clear write strobe (data is zero).
- CLR_ADDR  out  ADDR_W  RAM clear address.
- BUSY  out  1  high in every state except IDLE.
- CH_READY  out  1  histogram of ADC_SEL complete, awaiting readout.
- DONE  out  1  one-cycle pulse when the last channel is read out.
- SAMPLES_TAKEN  out  CNT_W  samples accumulated on current channel.
- TIMEOUT_ERR  out  1  sticky readout-timeout flag (0 when feature off).

Behaviour:
- Reset values: all outputs 0; state IDLE; latched mask and count 0.
- IDLE
  - START with CH_MASK!=0: latch mask and count, select lowest set bit -> CLEAR next cycle.
  - START with CH_MASK==0: DONE pulses the next cycle; stay IDLE.
- CLEAR
  - CLR_WE=1 for exactly 2**ADDR_W consecutive cycles; CLR_ADDR counts 0..4095, one per cycle.
  - After the address-4095 cycle -> ACQ. SAMPLES_TAKEN cleared on CLEAR entry.
- ACQ
  - HISTO_EN=1.
  - Each SAMPLE_VALID increments SAMPLES_TAKEN (CNT_W bits; saturation unreachable since the count stops at the target).
  - On the cycle the count reaches SAMPLE_COUNT: HISTO_EN drops the next cycle, -> DRAIN.
  - SAMPLE_VALID arriving in CLEAR or DRAIN is not counted.
- DRAIN: HISTO_EN=0 for DRAIN_CYC cycles -> READY.
- READY
  - CH_READY=1 until READOUT_DONE.
  - On READOUT_DONE: clear that mask bit. If bits remain, select the next lowest set bit -> CLEAR. Otherwise DONE pulses one cycle -> IDLE.
- ADC_SEL changes only on the CLEAR entry edge; stable through ACQ, DRAIN and READY.
- ABORT
  - Highest priority, including over START in the same cycle.
  - Next cycle: IDLE; HISTO_EN, CLR_WE and CH_READY are 0; DONE not pulsed; SAMPLES_TAKEN retained for diagnosis.
- RST mid-operation: identical to reset values; no DONE.
- READOUT_DONE outside READY is ignored.
- START while BUSY is ignored.

Optional Feature:
- Macro HISTO_SEQ_TIMEOUT_EN.
- When defined: a counter runs in READY. If it reaches TIMEOUT_CYC without READOUT_DONE, TIMEOUT_ERR is set (sticky until next START or RST) and the sequencer advances exactly as if READOUT_DONE had arrived.
- When undefined: READY waits indefinitely, TIMEOUT_ERR is tied 0, and no counter is synthesised.

Decomposition:
- Shared package histo_pkg holds:
  - state encoding constants: IDLE, CLEAR, ACQ, DRAIN, READY;
  - HISTO_ADDR_W=12;
  - HISTO_NCH=8.
- One sub-module, histo_prio_enc: an 8-bit lowest-set-bit priority encoder giving the index and a valid flag. It is used at START and at each advance.

Test Plan:
- CH_MASK=8'h05, SAMPLE_COUNT=10, SAMPLE_VALID every 3rd cycle, READOUT_DONE 20 cycles after CH_READY -> ADC_SEL=0 then 2; 4096 CLR_WE per channel; SAMPLES_TAKEN=10 each; one DONE pulse.
- CH_MASK=0 with START -> DONE one cycle later; BUSY stays 0.
- SAMPLE_VALID held high continuously, SAMPLE_COUNT=0 -> exactly 1 sample counted; HISTO_EN high for exactly 1 cycle after the first ACQ cycle.
- ABORT at CLR_ADDR=100, same cycle as a repeated START -> IDLE next cycle; CLR_WE=0; no DONE.
- SAMPLE_VALID during CLEAR and DRAIN -> SAMPLES_TAKEN unchanged; RST asserted in ACQ -> all outputs 0 next cycle.
- Feature on, TIMEOUT_CYC=50, no READOUT_DONE, mask 8'h81 -> TIMEOUT_ERR set 50 cycles into READY; advance to channel 7; next START clears TIMEOUT_ERR.
